// File: rtl/pic_pkg.sv
// Shared definitions for the PIC CPU-bus front end: default bus widths,
// the queued write entry layout and the A0 register-select encodings.
package pic_pkg;

    localparam int PIC_DATA_WIDTH = 8;
    localparam int PIC_ADDR_WIDTH = 1;

    typedef struct packed {
        logic [PIC_ADDR_WIDTH-1:0] addr;
        logic [PIC_DATA_WIDTH-1:0] data;
    } wr_entry_t;

    // A0=0 selects ICW1/OCW2/OCW3, A0=1 selects ICW2-4/OCW1 in 8259 mode.
    localparam logic A0_ICW1_OCW23  = 1'b0;
    localparam logic A0_ICW2_4_OCW1 = 1'b1;

endpackage

// File: rtl/pic_bus_interface_if.sv
// CPU strobes plus the internal write-queue and read-event signals of the
// PIC bus front end. The tri-state data bus stays a plain module port.
interface pic_bus_interface_if
    import pic_pkg::*;
#(
    parameter int DATA_WIDTH = PIC_DATA_WIDTH,
    parameter int ADDR_WIDTH = PIC_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
);
    logic                          cs_n;
    logic                          rd_n;
    logic                          wr_n;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic                          wr_valid;
    logic                          wr_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          rd_req;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          rd_done;
    logic                          clear_ovf;

    // Write queue handshake: wr_data/wr_addr are stable while wr_valid is high;
    // the head is consumed on a clock edge where wr_valid & wr_ready, and
    // wr_valid never drops without such a transfer.
    modport slave (
        input  cs_n, rd_n, wr_n, addr, wr_ready, rd_data, clear_ovf,
        output wr_data, wr_addr, wr_valid, fifo_count, overflow,
               rd_req, rd_addr, rd_done
    );

    modport master (
        output cs_n, rd_n, wr_n, addr, wr_ready, rd_data, clear_ovf,
        input  wr_data, wr_addr, wr_valid, fifo_count, overflow,
               rd_req, rd_addr, rd_done
    );

endinterface

// File: rtl/pic_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter. A push while full is
// dropped unless a pop frees the slot in the same cycle.
module pic_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign dropped  = push & full & ~pop_ok;
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pic_bus_interface.sv
// Synchronous PIC data bus buffer: synchronises CPU strobes, queues writes,
// snapshots read data and drives it onto the tri-state bus during reads.
module pic_bus_interface
    import pic_pkg::*;
#(
    parameter int DATA_WIDTH  = PIC_DATA_WIDTH,
    parameter int ADDR_WIDTH  = PIC_ADDR_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire [DATA_WIDTH-1:0]  data,
    pic_bus_interface_if.slave    bus
);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, fill;
    logic                   cs_s, rd_s, wr_s, filled, idle, illegal;
    logic                   armed, rd_act, wr_act, rd_act_q, wr_act_q;
    logic                   rd_start, rd_end, wr_end, cap_pending;
    logic [DATA_WIDTH-1:0]  read_reg, wr_hold_data;
    logic [ADDR_WIDTH-1:0]  wr_hold_addr, rd_addr_q;
    logic                   ovf_q, dropped, fifo_full, fifo_empty;
    logic [EW-1:0]          head;

    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign rd_s    = rd_sync[SYNC_STAGES-1];
    assign wr_s    = wr_sync[SYNC_STAGES-1];
    // The sync chain is preset to idle, so only trust it once real samples reach the end.
    assign filled  = fill[SYNC_STAGES-1];
    assign idle    = rd_s & wr_s;
    assign illegal = ~rd_s & ~wr_s;

    assign rd_act   = armed & ~cs_s & ~rd_s & wr_s;
    assign wr_act   = armed & ~cs_s & ~wr_s & rd_s;
    assign rd_start = rd_act & ~rd_act_q;
    // Leaving an access through the illegal both-low state raises no event.
    assign rd_end   = ~rd_act & rd_act_q & ~illegal;
    assign wr_end   = ~wr_act & wr_act_q & ~illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync      <= '1;
            rd_sync      <= '1;
            wr_sync      <= '1;
            fill         <= '0;
            armed        <= 1'b0;
            rd_act_q     <= 1'b0;
            wr_act_q     <= 1'b0;
            cap_pending  <= 1'b0;
            read_reg     <= '0;
            wr_hold_data <= '0;
            wr_hold_addr <= '0;
            rd_addr_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], bus.rd_n};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], bus.wr_n};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            if (illegal)            armed <= 1'b0;
            else if (filled & idle) armed <= 1'b1;
            rd_act_q    <= rd_act;
            wr_act_q    <= wr_act;
            cap_pending <= rd_start;
            if (rd_start)    rd_addr_q <= bus.addr;
            if (cap_pending) read_reg  <= bus.rd_data;
            if (wr_act) begin
                wr_hold_data <= data;
                wr_hold_addr <= bus.addr;
            end
            if (dropped)            ovf_q <= 1'b1;
            else if (bus.clear_ovf) ovf_q <= 1'b0;
        end
    end

    pic_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_end),
        .push_data ({wr_hold_addr, wr_hold_data}),
        .pop       (bus.wr_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.fifo_count),
        .dropped   (dropped)
    );

    assign data         = rd_act ? read_reg : 'z;
    assign bus.wr_valid = ~fifo_empty;
    assign bus.wr_addr  = head[EW-1:DATA_WIDTH];
    assign bus.wr_data  = head[DATA_WIDTH-1:0];
    assign bus.overflow = ovf_q;
    assign bus.rd_req   = rd_start;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_done  = rd_end;

endmodule

// File: tb/tb_pic_bus_interface.sv
// Bench for pic_bus_interface: directed and random CPU bus traffic checked
// against a queue-based model of strobe latency, write queue and read bus.
module tb_pic_bus_interface;
    import pic_pkg::*;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       clk;
    logic       reset;
    tri1  [7:0] data;
    logic       tb_drv;
    logic [7:0] tb_data;

    assign data = tb_drv ? tb_data : 'z;

    pic_bus_interface_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .FIFO_DEPTH(DEPTH)) bus_if ();

    pic_bus_interface #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (1),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .bus   (bus_if)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard and reference model state
    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    wr_entry_t  pend;
    bit         exp_ovf, push_now, rd_req_now, rd_done_now, cap_now, exp_rd_act, rand_mode;
    logic [7:0] exp_snap;
    int         wr_cd, rd_rise_cd, rd_fall_cd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: the model applies what the strobes/handshake imply at this edge.
    task automatic tick();
        bit         do_pop, do_push, do_cap, drop;
        logic [7:0] cap_val;
        if (rand_mode) begin
            bus_if.wr_ready  = ($urandom_range(0, 3) != 0);
            bus_if.clear_ovf = ($urandom_range(0, 15) == 0);
        end
        do_pop  = (bus_if.wr_ready === 1'b1) && (exp_q.size() > 0);
        do_push = push_now;
        do_cap  = cap_now;
        cap_val = bus_if.rd_data;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            exp_ovf = 0; push_now = 0; rd_req_now = 0; rd_done_now = 0;
            cap_now = 0; exp_rd_act = 0; exp_snap = '0;
            wr_cd = 0; rd_rise_cd = 0; rd_fall_cd = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            drop = do_push && (exp_q.size() >= DEPTH);
            if (do_push && !drop) exp_q.push_back(pend);
            if (drop) exp_ovf = 1'b1;
            else if (bus_if.clear_ovf) exp_ovf = 1'b0;
            if (do_cap) exp_snap = cap_val;
            cap_now     = rd_req_now;
            push_now    = 0;
            rd_req_now  = 0;
            rd_done_now = 0;
            if (wr_cd > 0) begin
                wr_cd--;
                if (wr_cd == 0) push_now = 1;
            end
            if (rd_rise_cd > 0) begin
                rd_rise_cd--;
                if (rd_rise_cd == 0) begin rd_req_now = 1; exp_rd_act = 1; end
            end
            if (rd_fall_cd > 0) begin
                rd_fall_cd--;
                if (rd_fall_cd == 0) begin rd_done_now = 1; exp_rd_act = 0; end
            end
        end
        #1;
        check("wr_valid", bus_if.wr_valid, exp_q.size() > 0);
        check("fifo_count", bus_if.fifo_count, exp_q.size());
        if (exp_q.size() > 0) check("fifo_head", {bus_if.wr_addr, bus_if.wr_data}, exp_q[0]);
        check("overflow", bus_if.overflow, exp_ovf);
        check("rd_req", bus_if.rd_req, rd_req_now);
        check("rd_done", bus_if.rd_done, rd_done_now);
        if (exp_rd_act) check("bus_drive", data, exp_snap);
        else if (!tb_drv) check("bus_release", data, 8'hFF);
    endtask

    // driver tasks
    task automatic do_write(input logic a, input logic [7:0] d, input int len, input bit ready_at_push);
        bus_if.addr = a;
        tb_data     = d;
        tb_drv      = 1'b1;
        bus_if.cs_n = 1'b0;
        bus_if.wr_n = 1'b0;
        repeat (len) tick();
        bus_if.wr_n = 1'b1;
        bus_if.cs_n = 1'b1;
        wr_cd       = SYNC;
        pend        = '{addr: a, data: d};
        for (int i = 0; i < 10 && !push_now; i++) tick();
        if (!push_now) check("push_timeout", 0, 1);
        if (ready_at_push) bus_if.wr_ready = 1'b1;
        tick();
        if (ready_at_push) bus_if.wr_ready = 1'b0;
        tb_drv = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_read(input logic a, input logic [7:0] val, input int hold);
        bus_if.rd_data = 8'($urandom_range(0, 254));
        bus_if.addr    = a;
        bus_if.cs_n    = 1'b0;
        bus_if.rd_n    = 1'b0;
        rd_rise_cd     = SYNC;
        for (int i = 0; i < 10 && !rd_req_now; i++) tick();
        if (!rd_req_now) check("rd_req_timeout", 0, 1);
        tick();
        check("rd_addr", bus_if.rd_addr, a);
        bus_if.rd_data = val;
        repeat (hold) tick();
        check("rd_value", data, val);
        bus_if.rd_n = 1'b1;
        bus_if.cs_n = 1'b1;
        rd_fall_cd  = SYNC;
        for (int i = 0; i < 10 && !rd_done_now; i++) tick();
        if (!rd_done_now) check("rd_done_timeout", 0, 1);
        bus_if.rd_data = 8'($urandom_range(0, 254));
        repeat (3) tick();
    endtask

    task automatic drain();
        bus_if.wr_ready = 1'b1;
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) tick();
        bus_if.wr_ready = 1'b0;
        tick();
        check("drained", bus_if.fifo_count, 0);
    endtask

    initial begin
        reset = 1'b1;
        tb_drv = 1'b0; tb_data = '0;
        bus_if.cs_n = 1'b0; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b0;
        bus_if.addr = '0; bus_if.wr_ready = 1'b0; bus_if.rd_data = '0; bus_if.clear_ovf = 1'b0;
        rand_mode = 0;

        // reset with wr_n held low, then released: no push may appear
        repeat (4) tick();
        check("reset_count", bus_if.fifo_count, 0);
        check("reset_ovf", bus_if.overflow, 0);
        reset = 1'b0;
        repeat (4) tick();
        bus_if.wr_n = 1'b1;
        bus_if.cs_n = 1'b1;
        repeat (6) tick();

        // single write, valid SYNC+1 clocks after wr_n rises
        do_write(A0_ICW2_4_OCW1, 8'hA5, 3, 0);
        check("a5_data", bus_if.wr_data, 8'hA5);
        check("a5_addr", bus_if.wr_addr, 1);
        drain();

        // five writes into a four-entry queue
        for (int i = 1; i <= 5; i++) do_write(1'($urandom_range(0, 1)), 8'(i), 2, 0);
        check("full_count", bus_if.fifo_count, 4);
        check("full_ovf", bus_if.overflow, 1);
        drain();
        bus_if.clear_ovf = 1'b1;
        tick();
        bus_if.clear_ovf = 1'b0;
        tick();
        check("ovf_cleared", bus_if.overflow, 0);

        // full queue, pop and push at the same edge
        for (int i = 0; i < 4; i++) do_write(1'b0, 8'h10 + 8'(i), 2, 0);
        do_write(1'b1, 8'h14, 3, 1);
        check("pp_count", bus_if.fifo_count, 4);
        check("pp_ovf", bus_if.overflow, 0);
        check("pp_tail", exp_q[3], {1'b1, 8'h14});
        drain();

        // read with snapshot 3C
        do_read(A0_ICW1_OCW23, 8'h3C, 4);
        do_read(A0_ICW2_4_OCW1, 8'h5A, 2);

        // illegal both-low strobes
        bus_if.cs_n = 1'b0; bus_if.rd_n = 1'b0; bus_if.wr_n = 1'b0;
        repeat (6) tick();
        bus_if.cs_n = 1'b1; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
        repeat (5) tick();
        check("illegal_count", bus_if.fifo_count, 0);

        // randomized traffic with random wr_ready / clear_ovf
        rand_mode = 1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(2, 4), 0);
                1: do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), $urandom_range(2, 5));
                default: repeat ($urandom_range(1, 3)) tick();
            endcase
        end
        rand_mode = 0;
        bus_if.clear_ovf = 1'b0;
        drain();

        // reset in the middle of a read with queued writes
        do_write(1'b0, 8'h66, 2, 0);
        do_write(1'b1, 8'h77, 2, 0);
        bus_if.rd_data = 8'h21;
        bus_if.cs_n = 1'b0; bus_if.rd_n = 1'b0;
        rd_rise_cd = SYNC;
        for (int i = 0; i < 10 && !rd_req_now; i++) tick();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_count", bus_if.fifo_count, 0);
        check("rst_mid_bus", data, 8'hFF);
        reset = 1'b0;
        repeat (3) tick();
        bus_if.cs_n = 1'b1; bus_if.rd_n = 1'b1;
        repeat (6) tick();
        do_read(1'b1, 8'h42, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
